// File: rtl/irq_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_req_ctrl
//  Purpose  : Request-conditioning stage in front of the interrupt priority
//             determiner. Samples the NMI and eight external IRQ pins,
//             detects the per-IRQ sense (low level / falling / rising / both),
//             latches edge events and internal event pulses into pending
//             flags, and clears them when the CPU acknowledges the matching
//             vector number (NMI = 1, IRQi = 2+i, internal IRQi = 10+i).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   system clock, rising edge
//    rst          in   1   asynchronous active-high reset
//    nmi_pin      in   1   raw NMI pin (rising edge sensitive, unmaskable)
//    irq_pin      in   8   raw external IRQ pins
//    int_src      in   8   internal event pulses, synchronous to clk
//    sense_cfg    in  16   [2i+1:2i] for IRQi: 00 low, 01 fall, 10 rise, 11 both
//    irq_en       in   8   external IRQ enables
//    int_en       in   8   internal IRQ enables
//    ack          in   1   one-cycle acknowledge strobe
//    ack_vt_no    in   5   vector number being acknowledged
//    nmi_req      out  1   latched NMI request
//    irq_req      out  8   external pending AND enable
//    int_irq_req  out  8   internal pending AND enable
//    irq_pend     out  8   raw external pending flags
// ----------------------------------------------------------------------------
//  Build option
//    IRQ_SYNC_EN  when defined, nmi_pin and irq_pin pass through a two-flop
//                 synchroniser; otherwise the pins are used directly.
// ============================================================================
module irq_req_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_pin,
    input  logic [7:0]  irq_pin,
    input  logic [7:0]  int_src,
    input  logic [15:0] sense_cfg,
    input  logic [7:0]  irq_en,
    input  logic [7:0]  int_en,
    input  logic        ack,
    input  logic [4:0]  ack_vt_no,
    output logic        nmi_req,
    output logic [7:0]  irq_req,
    output logic [7:0]  int_irq_req,
    output logic [7:0]  irq_pend
);

    localparam logic [4:0] c_VT_NMI      = 5'd1;
    localparam int         c_VT_IRQ_BASE = 2;
    localparam int         c_VT_INT_BASE = 10;

    // Bit 8 carries the NMI, bits 7:0 the external IRQs.
    logic [8:0] w_s;          // sampled pin level
    logic [8:0] r_prev;       // previous sampled level
    logic       w_s_valid;    // w_s holds a real pin sample (not reset fill)
    logic       w_p_valid;    // r_prev holds a real pin sample

`ifdef IRQ_SYNC_EN
    logic [8:0] r_meta;
    logic [8:0] r_sync;
    logic [1:0] r_warm;       // edges since reset, saturating at 3

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_warm <= 2'd0;
        end else begin
            r_meta <= {nmi_pin, irq_pin};
            r_sync <= r_meta;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    assign w_s       = r_sync;
    // The synchroniser needs two edges before its output reflects the pin,
    // and one more before the previous-value register does. Until then the
    // zeros left by reset must not look like a low level or an edge.
    assign w_s_valid = r_warm[1];
    assign w_p_valid = (r_warm == 2'd3);
`else
    logic r_primed;           // first edge after reset has been taken

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_primed <= 1'b0;
        end else begin
            r_primed <= 1'b1;
        end
    end

    assign w_s       = {nmi_pin, irq_pin};
    assign w_s_valid = 1'b1;
    // r_prev holds reset zeros until the first edge; a pin already high at
    // release must not read as a rising edge.
    assign w_p_valid = r_primed;
`endif

    logic [8:0] w_rise;
    logic [7:0] w_fall;

    assign w_rise = w_s & ~r_prev & {9{w_p_valid}};
    assign w_fall = ~w_s[7:0] & r_prev[7:0] & {8{w_p_valid}};

    logic [7:0] r_pend;
    logic [7:0] r_ipend;
    logic       r_nmi;

    logic [7:0] w_edge;
    logic [7:0] w_ack_irq;
    logic [7:0] w_ack_int;
    logic       w_ack_nmi;
    logic [7:0] w_pend_nxt;

    assign w_ack_nmi = ack && (ack_vt_no == c_VT_NMI);

    always_comb begin
        w_edge     = '0;
        w_ack_irq  = '0;
        w_ack_int  = '0;
        w_pend_nxt = r_pend;
        for (int i = 0; i < 8; i++) begin
            w_ack_irq[i] = ack && (ack_vt_no == 5'(c_VT_IRQ_BASE + i));
            w_ack_int[i] = ack && (ack_vt_no == 5'(c_VT_INT_BASE + i));

            case (sense_cfg[2*i +: 2])
                2'b01:   w_edge[i] = w_fall[i];
                2'b10:   w_edge[i] = w_rise[i];
                2'b11:   w_edge[i] = w_rise[i] | w_fall[i];
                default: w_edge[i] = 1'b0;
            endcase

            if (sense_cfg[2*i +: 2] == 2'b00) begin
                // Low level: the flag simply mirrors the inverted pin, so an
                // acknowledge cannot remove a request that is still asserted.
                if (w_s_valid) begin
                    w_pend_nxt[i] = ~w_s[i];
                end
            end else if (w_edge[i] && irq_en[i]) begin
                // Edges seen while disabled are dropped, not deferred.
                w_pend_nxt[i] = 1'b1;
            end else if (w_ack_irq[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev  <= '0;
            r_pend  <= '0;
            r_ipend <= '0;
            r_nmi   <= 1'b0;
        end else begin
            r_prev  <= w_s;
            r_pend  <= w_pend_nxt;
            // Set terms are OR-ed after the clear so a new event wins.
            r_ipend <= (r_ipend & ~w_ack_int) | (int_src & int_en);
            r_nmi   <= (r_nmi & ~w_ack_nmi) | w_rise[8];
        end
    end

    assign nmi_req     = r_nmi;
    assign irq_req     = r_pend & irq_en;
    assign int_irq_req = r_ipend & int_en;
    assign irq_pend    = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_irq_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_req_ctrl
//  Purpose  : Self-checking bench for irq_req_ctrl. A sample-history model
//             predicts every output each cycle; directed sequences add
//             hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_irq_req_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int c_D = 2;    // edges between pin sample and usable level
`else
    localparam int c_D = 0;
`endif
    localparam int c_LAT = c_D + 1;

    logic        clk;
    logic        rst;
    logic        nmi_pin;
    logic [7:0]  irq_pin;
    logic [7:0]  int_src;
    logic [15:0] sense_cfg;
    logic [7:0]  irq_en;
    logic [7:0]  int_en;
    logic        ack;
    logic [4:0]  ack_vt_no;
    logic        nmi_req;
    logic [7:0]  irq_req;
    logic [7:0]  int_irq_req;
    logic [7:0]  irq_pend;

    int n_tests = 0;
    int n_fail  = 0;

    irq_req_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .nmi_pin     (nmi_pin),
        .irq_pin     (irq_pin),
        .int_src     (int_src),
        .sense_cfg   (sense_cfg),
        .irq_en      (irq_en),
        .int_en      (int_en),
        .ack         (ack),
        .ack_vt_no   (ack_vt_no),
        .nmi_req     (nmi_req),
        .irq_req     (irq_req),
        .int_irq_req (int_irq_req),
        .irq_pend    (irq_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%02h required=%02h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: keeps the last three pin samples per line (-1 = no sample yet
    // since reset). The level seen at an edge is the pin sampled c_D edges
    // earlier, the previous level one edge before that.
    // ------------------------------------------------------------------
    int         m_h [9][3];
    logic [7:0] m_pend;
    logic [7:0] m_ipend;
    logic       m_nmi;

    always @(posedge clk or posedge rst) begin : model
        int         smp [4];
        int         s;
        int         p;
        logic [1:0] mode;
        logic       hit;
        logic [8:0] pins;
        if (rst) begin
            for (int n = 0; n < 9; n++)
                for (int j = 0; j < 3; j++)
                    m_h[n][j] <= -1;
            m_pend  <= '0;
            m_ipend <= '0;
            m_nmi   <= 1'b0;
        end else begin
            pins = {nmi_pin, irq_pin};
            for (int n = 0; n < 9; n++) begin
                smp[0] = int'(pins[n]);
                for (int j = 1; j < 4; j++) smp[j] = m_h[n][j-1];
                s = smp[c_D];
                p = smp[c_D+1];
                if (n == 8) begin
                    if (s == 1 && p == 0)              m_nmi <= 1'b1;
                    else if (ack && ack_vt_no == 1)    m_nmi <= 1'b0;
                end else begin
                    mode = sense_cfg[2*n +: 2];
                    if (mode == 2'b00) begin
                        if (s >= 0) m_pend[n] <= (s == 0);
                    end else begin
                        hit = (s == 1 && p == 0 && mode[1]) || (s == 0 && p == 1 && mode[0]);
                        if (hit && irq_en[n])                 m_pend[n] <= 1'b1;
                        else if (ack && ack_vt_no == n + 2)   m_pend[n] <= 1'b0;
                    end
                end
                for (int j = 0; j < 3; j++) m_h[n][j] <= smp[j];
            end
            for (int i = 0; i < 8; i++) begin
                if (int_src[i] && int_en[i])              m_ipend[i] <= 1'b1;
                else if (ack && ack_vt_no == i + 10)      m_ipend[i] <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("m_nmi_req", {7'd0, nmi_req}, {7'd0, m_nmi});
        chk("m_irq_req", irq_req, m_pend & irq_en);
        chk("m_int_req", int_irq_req, m_ipend & int_en);
        chk("m_irq_pend", irq_pend, m_pend);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ack(input logic [4:0] vt);
        ack       = 1'b1;
        ack_vt_no = vt;
        cyc(1);
        ack       = 1'b0;
        ack_vt_no = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        nmi_pin   = 1'b0;
        irq_pin   = 8'hFF;
        int_src   = 8'h00;
        sense_cfg = 16'hAAAA;   // all rising edge
        irq_en    = 8'h00;
        int_en    = 8'h00;
        ack       = 1'b0;
        ack_vt_no = 5'd0;

        cyc(2);
        chk("rst_irq_req", irq_req, 8'h00);
        chk("rst_irq_pend", irq_pend, 8'h00);
        chk("rst_int_req", int_irq_req, 8'h00);
        chk("rst_nmi", {7'd0, nmi_req}, 8'h00);
        rst = 1'b0;
        cyc(5);
        chk("high_at_release", irq_pend, 8'h00);

        // Rising edge on IRQ0; the falling edge first must be ignored.
        irq_en     = 8'h01;
        irq_pin[0] = 1'b0;
        cyc(5);
        chk("fall_in_rise_mode", irq_req, 8'h00);
        irq_pin[0] = 1'b1;
        cyc(c_LAT - 1);
        chk("rise_early", irq_req, 8'h00);
        cyc(1);
        chk("rise", irq_req, 8'h01);
        do_ack(5'd2);
        chk("rise_ack", irq_req, 8'h00);

        // Low level on IRQ2; acknowledge has no effect.
        sense_cfg[5:4] = 2'b00;
        irq_en         = 8'h04;
        cyc(c_LAT + 1);
        chk("lvl_idle", irq_req, 8'h00);
        irq_pin[2] = 1'b0;
        cyc(c_LAT);
        chk("lvl", irq_req, 8'h04);
        do_ack(5'd4);
        chk("lvl_ack", irq_req, 8'h04);
        irq_pin[2] = 1'b1;
        cyc(c_LAT - 1);
        chk("lvl_hold", irq_req, 8'h04);
        cyc(1);
        chk("lvl_release", irq_req, 8'h00);

        // Falling edge on IRQ1, then a sense change keeps the pending flag.
        sense_cfg[3:2] = 2'b01;
        irq_en         = 8'h02;
        cyc(1);
        irq_pin[1] = 1'b0;
        cyc(c_LAT);
        chk("fall", irq_req, 8'h02);
        sense_cfg[3:2] = 2'b10;
        cyc(2);
        chk("sense_change", irq_req, 8'h02);
        do_ack(5'd3);
        chk("fall_ack", irq_req, 8'h00);
        irq_pin[1] = 1'b1;

        // Edge on IRQ6 while disabled is dropped.
        irq_en     = 8'h00;
        irq_pin[6] = 1'b0;
        cyc(3);
        irq_pin[6] = 1'b1;
        cyc(c_LAT + 2);
        irq_en = 8'h40;
        #1;
        chk("dropped_edge", irq_req, 8'h00);
        irq_en = 8'h00;

        // Internal pulse on IRQ7.
        int_en  = 8'h88;
        int_src = 8'h80;
        cyc(1);
        int_src = 8'h00;
        chk("int7", int_irq_req, 8'h80);
        do_ack(5'd17);
        chk("int7_ack", int_irq_req, 8'h00);

        // Set/clear collision on internal IRQ3.
        int_src = 8'h08;
        cyc(1);
        int_src = 8'h00;
        chk("int3", int_irq_req, 8'h08);
        int_src   = 8'h08;
        ack       = 1'b1;
        ack_vt_no = 5'd13;
        cyc(1);
        int_src   = 8'h00;
        ack       = 1'b0;
        chk("collision", int_irq_req, 8'h08);
        do_ack(5'd13);
        chk("int3_ack", int_irq_req, 8'h00);

        // NMI with every enable cleared.
        int_en  = 8'h00;
        nmi_pin = 1'b1;
        cyc(c_LAT);
        chk("nmi", {7'd0, nmi_req}, 8'h01);
        do_ack(5'd2);
        chk("nmi_ack2", {7'd0, nmi_req}, 8'h01);
        do_ack(5'd0);
        chk("nmi_ack0", {7'd0, nmi_req}, 8'h01);
        do_ack(5'd20);
        chk("nmi_ack20", {7'd0, nmi_req}, 8'h01);
        do_ack(5'd1);
        chk("nmi_ack1", {7'd0, nmi_req}, 8'h00);

        // Mask keeps the pending flag; asynchronous reset clears it.
        irq_en     = 8'h20;
        irq_pin[5] = 1'b0;
        cyc(2);
        irq_pin[5] = 1'b1;
        cyc(c_LAT);
        chk("irq5", irq_req, 8'h20);
        irq_en = 8'h00;
        #1;
        chk("mask_req", irq_req, 8'h00);
        chk("mask_pend", irq_pend, 8'h20);
        irq_en = 8'h20;
        #1;
        chk("unmask", irq_req, 8'h20);
        rst = 1'b1;
        #1;
        chk("arst_irq_req", irq_req, 8'h00);
        chk("arst_irq_pend", irq_pend, 8'h00);
        chk("arst_nmi", {7'd0, nmi_req}, 8'h00);
        chk("arst_int", int_irq_req, 8'h00);
        cyc(2);
        rst = 1'b0;
        cyc(6);
        chk("no_recovery", irq_pend, 8'h00);
        chk("nmi_no_recovery", {7'd0, nmi_req}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
